hamming_decode_ctrl: RTL and testbench

Sequencing controller for the SECDED Hamming decoder. It accepts 8-bit codewords over a valid/ready handshake and presents each one to the external combinational decoder for one cycle. It then returns the result as a two-beat stream: the corrected codeword first, then an error-info byte. It also keeps saturating counts of single-bit and double-bit error events for the top-level status readout.

---
 rtl/hamming_decode_ctrl.sv | 124 ++++++++++++
 tb/tb_hamming_decode_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decode_ctrl.sv
// Sequencing controller around an external combinational SECDED decoder:
// accept a codeword, decode for one cycle, emit corrected code then error info.
module hamming_decode_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_code,
  output logic [7:0]       dec_code_in,
  input  logic [7:0]       dec_code_out,
  input  logic [2:0]       dec_err_loc,
  input  logic [1:0]       dec_err_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] single_cnt,
  output logic [CNT_W-1:0] double_cnt
);

  localparam int unsigned CODE_W = 8;
  localparam int unsigned INFO_W = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    SEND_DATA = 2'd2,
    SEND_INFO = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] data_q, data_d;
  logic [INFO_W-1:0] info_q, info_d;
  logic [CNT_W-1:0]  single_q, single_d;
  logic [CNT_W-1:0]  double_q, double_d;
  logic [1:0]        flag_norm;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      code_q   <= '0;
      data_q   <= '0;
      info_q   <= '0;
      single_q <= '0;
      double_q <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      data_q   <= data_d;
      info_q   <= info_d;
      single_q <= single_d;
      double_q <= double_d;
    end
  end

  // Next-state, capture, counter and beat output logic
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    data_d    = data_q;
    info_d    = info_q;
    single_d  = single_q;
    double_d  = double_q;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    flag_norm = (dec_err_flag == 2'b11) ? 2'b10 : dec_err_flag;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          code_d  = in_code;
          state_d = DECODE;
        end
      end
      DECODE: begin
        data_d = dec_code_out;
        info_d = {dec_err_loc, flag_norm};
        if (flag_norm == 2'b01 && single_q != CNT_MAX) begin
          single_d = single_q + CNT_W'(1);
        end
        if (flag_norm == 2'b10 && double_q != CNT_MAX) begin
          double_d = double_q + CNT_W'(1);
        end
        state_d = SEND_DATA;
      end
      SEND_DATA: begin
        out_valid = 1'b1;
        out_data  = data_q;
        if (out_ready) begin
          state_d = SEND_INFO;
        end
      end
      SEND_INFO: begin
        out_valid = 1'b1;
        out_data  = {3'b000, info_q};
        out_last  = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over a same-cycle increment
    if (cnt_clr) begin
      single_d = '0;
      double_d = '0;
    end
  end

  // in_ready is forced low while reset is held
  assign in_ready    = rst_n & (state_q == IDLE);
  assign dec_code_in = code_q;
  assign single_cnt  = single_q;
  assign double_cnt  = double_q;

endmodule

// File: tb/tb_hamming_decode_ctrl.sv
// Directed bench for hamming_decode_ctrl with a behavioural SECDED decoder model.
module tb_hamming_decode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_code;
  logic [7:0] dec_code_in;
  logic [7:0] dec_code_out;
  logic [2:0] dec_err_loc;
  logic [1:0] dec_err_flag;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       cnt_clr;
  logic [7:0] single_cnt;
  logic [7:0] double_cnt;

  logic       force_flag3;
  int         checks = 0;
  int         errors = 0;
  int         exp_sc = 0;
  int         exp_dc = 0;

  always #5 clk = ~clk;

  hamming_decode_ctrl #(.CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_code      (in_code),
    .dec_code_in  (dec_code_in),
    .dec_code_out (dec_code_out),
    .dec_err_loc  (dec_err_loc),
    .dec_err_flag (dec_err_flag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .cnt_clr      (cnt_clr),
    .single_cnt   (single_cnt),
    .double_cnt   (double_cnt)
  );

  // Hamming(7,4)+overall parity; syndrome is the XOR of set bit positions 1..7
  function automatic logic [12:0] dec_model(input logic [7:0] c);
    logic [2:0] s;
    logic       p;
    logic [7:0] o;
    logic [1:0] f;
    s = 3'd0;
    for (int i = 1; i <= 7; i++) begin
      if (c[i-1]) s = s ^ 3'(i);
    end
    p = ^c;
    o = c;
    if (s == 3'd0 && !p) begin
      f = 2'b00;
    end else if (p && s != 3'd0) begin
      f = 2'b01;
      o[int'(s) - 1] = ~o[int'(s) - 1];
    end else begin
      f = 2'b10;
    end
    return {o, s, f};
  endfunction

  always_comb begin
    {dec_code_out, dec_err_loc, dec_err_flag} = dec_model(dec_code_in);
    if (force_flag3) dec_err_flag = 2'b11;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction; stall = extra cycles out_ready is held low per beat
  task automatic send_word(input logic [7:0] code, input logic [7:0] exp_d,
                           input logic [7:0] exp_i, input int stall, input bit clr);
    @(negedge clk);
    check("ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_code  = code;
    @(negedge clk);
    in_valid = 1'b0;
    in_code  = 8'h55;
    check("dec_code_in", 32'(dec_code_in), 32'(code));
    check("decode_valid", 32'(out_valid), 32'd0);
    check("decode_ready", 32'(in_ready), 32'd0);
    if (clr) cnt_clr = 1'b1;
    if (clr) begin
      exp_sc = 0;
      exp_dc = 0;
    end else if (exp_i[1:0] == 2'b01) begin
      if (exp_sc < 255) exp_sc++;
    end else if (exp_i[1:0] != 2'b00) begin
      if (exp_dc < 255) exp_dc++;
    end
    @(negedge clk);
    cnt_clr = 1'b0;
    check("beat0_latency", 32'(out_valid), 32'd1);
    check("beat0_data", 32'(out_data), 32'(exp_d));
    check("beat0_last", 32'(out_last), 32'd0);
    check("single_cnt", 32'(single_cnt), 32'(exp_sc));
    check("double_cnt", 32'(double_cnt), 32'(exp_dc));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("stall0_valid", 32'(out_valid), 32'd1);
      check("stall0_data", 32'(out_data), 32'(exp_d));
      check("stall0_last", 32'(out_last), 32'd0);
      check("stall0_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("beat1_valid", 32'(out_valid), 32'd1);
    check("beat1_data", 32'(out_data), 32'(exp_i));
    check("beat1_last", 32'(out_last), 32'd1);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("stall1_valid", 32'(out_valid), 32'd1);
      check("stall1_data", 32'(out_data), 32'(exp_i));
      check("stall1_last", 32'(out_last), 32'd1);
      check("stall1_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("done_valid", 32'(out_valid), 32'd0);
    check("done_data", 32'(out_data), 32'd0);
    check("done_last", 32'(out_last), 32'd0);
    check("done_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input logic exp_ready);
    check("rst_in_ready", 32'(in_ready), 32'(exp_ready));
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_dec_code_in", 32'(dec_code_in), 32'd0);
    check("rst_single_cnt", 32'(single_cnt), 32'd0);
    check("rst_double_cnt", 32'(double_cnt), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b1;
    in_valid    = 1'b0;
    in_code     = 8'h00;
    out_ready   = 1'b0;
    cnt_clr     = 1'b0;
    force_flag3 = 1'b0;

    // Reset asserted mid-cycle, then released mid-cycle
    #3 rst_n = 1'b0;
    #1 check_reset_outputs(1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check_reset_outputs(1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_ready", 32'(in_ready), 32'd1);
    end

    // Clean, single, double, and a few more hand-decoded words
    send_word(8'h00, 8'h00, 8'h00, 0, 1'b0);
    send_word(8'h01, 8'h00, 8'h05, 0, 1'b0);
    send_word(8'h80, 8'h80, 8'h02, 0, 1'b0);
    send_word(8'h87, 8'h87, 8'h00, 0, 1'b0);
    send_word(8'h04, 8'h00, 8'h0D, 0, 1'b0);

    // Backpressure on both beats
    send_word(8'hC7, 8'h87, 8'h1D, 5, 1'b0);
    send_word(8'h03, 8'h03, 8'h0E, 5, 1'b0);

    // Decoder flag 11 is stored and counted as double
    force_flag3 = 1'b1;
    send_word(8'h03, 8'h03, 8'h0E, 0, 1'b0);
    force_flag3 = 1'b0;

    // Saturate the single-error counter
    for (int n = 0; n < 300; n++) begin
      send_word(8'h01, 8'h00, 8'h05, 0, 1'b0);
    end
    check("single_saturated", 32'(single_cnt), 32'd255);

    // Clear in the same cycle as a double-error DECODE
    send_word(8'h80, 8'h80, 8'h02, 0, 1'b1);
    check("clr_single", 32'(single_cnt), 32'd0);
    check("clr_double", 32'(double_cnt), 32'd0);

    send_word(8'h01, 8'h00, 8'h05, 0, 1'b0);

    // Reset during SEND_DATA discards the word
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = 8'h80;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(1'b0);
    exp_sc = 0;
    exp_dc = 0;
    out_ready = 1'b1;
    @(negedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(out_valid), 32'd0);
      check("post_rst_last", 32'(out_last), 32'd0);
      check("post_rst_ready", 32'(in_ready), 32'd1);
    end
    out_ready = 1'b0;
    send_word(8'h00, 8'h00, 8'h00, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
